// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a sticky
// single-byte valid/ack output with framing-error and overrun flags.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int CNT_W        = 14
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rxs;

  assign rxs = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    sync1_d     = UART_RX;
    sync2_d     = sync1_q;

    if (rx_ack) begin
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            // A byte landing on the ack cycle replaces the acked one without overrun.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = overrun_d | (rx_valid_q & ~rx_ack);
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BRK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at 16 clocks per bit: stimulus queues
// expected bytes, a negedge monitor checks each delivery as it appears.
`timescale 1ns/1ps
module tb_uart_rx_frontend;
  localparam int C   = 16;
  localparam int LAT = 3 + C/2 + 9*C;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  uart_rx_frontend #(.CLKS_PER_BIT(C), .CNT_W(14)) dut (
    .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       ov;
    int         t;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // Monitor: a delivery is rx_valid rising, or rx_data changing while valid.
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;
  always @(negedge sysclk) begin
    if (rx_valid && (!prev_v || rx_data != prev_d)) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_delivery: got data 0x%0h, required no delivery", rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rx_data", int'(rx_data), int'(e.data));
        check("frame_err_at_delivery", int'(frame_err), int'(e.fe));
        check("overrun_at_delivery", int'(overrun), int'(e.ov));
        check("delivery_cycle", cyc, e.t);
      end
    end
    prev_v = rx_valid;
    prev_d = rx_data;
  end

  task automatic send(input logic [7:0] d, input logic stop, input logic ack_sim,
                      input logic expect_ok, input logic efe, input logic eov);
    logic [9:0] fr;
    exp_t e;
    fr = {stop, d, 1'b0};
    if (expect_ok) begin
      e.data = d; e.fe = efe; e.ov = eov; e.t = cyc + LAT;
      sb.push_back(e);
    end
    for (int k = 0; k < 10*C; k++) begin
      UART_RX = fr[k/C];
      if (ack_sim) rx_ack = (k == LAT - 1);
      tick(1);
    end
    rx_ack  = 1'b0;
    UART_RX = stop;
    if (expect_ok) begin
      check("frame_delivered", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    int bad;
    logic saw;
    logic [9:0] fr;

    // 1. reset then idle
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("reset_outputs", int'({rx_data, rx_valid, frame_err, overrun, busy}), 0);
    bad = 0;
    repeat (200) begin
      tick(1);
      if ({rx_data, rx_valid, frame_err, overrun, busy} != 12'h0) bad++;
    end
    check("idle_line_quiet", bad, 0);

    // 2. single frame, sticky valid, ack
    send(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(100);
    check("valid_held_no_ack", int'(rx_valid), 1);
    check("data_held_no_ack", int'(rx_data), 8'h55);
    ack_pulse();
    check("ack_clears_valid", int'(rx_valid), 0);

    // 3. start glitch
    saw = 1'b0;
    UART_RX = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (busy) saw = 1'b1;
    end
    UART_RX = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (busy) saw = 1'b1;
    end
    check("glitch_busy_seen", int'(saw), 1);
    check("glitch_busy_returns", int'(busy), 0);
    check("glitch_no_valid_no_fe", int'({rx_valid, frame_err}), 0);
    tick(5);
    send(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    ack_pulse();

    // 4. framing error, line held low, then a good frame
    send(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3*C);
    check("framing_err_set", int'(frame_err), 1);
    check("framing_err_no_valid", int'(rx_valid), 0);
    check("framing_err_data_kept", int'(rx_data), 8'hC3);
    UART_RX = 1'b1;
    tick(4);
    check("break_released_idle", int'(busy), 0);
    tick(4);
    send(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("fe_sticky_after_good", int'(frame_err), 1);
    ack_pulse();
    check("ack_clears_fe_valid", int'({rx_valid, frame_err, overrun}), 0);

    // 5. overrun, then ack coinciding with completion
    send(8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("overrun_set", int'(overrun), 1);
    ack_pulse();
    check("ack_clears_overrun", int'({rx_valid, overrun}), 0);
    tick(3);
    send(8'h56, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sim_ack_valid_kept", int'(rx_valid), 1);
    send(8'h78, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sim_ack_new_byte_wins", int'({rx_data, rx_valid, overrun}), int'({8'h78, 1'b1, 1'b0}));

    // 6. reset mid-frame
    fr = {1'b1, 8'hFF, 1'b0};
    for (int k = 0; k < 5*C; k++) begin
      UART_RX = fr[k/C];
      tick(1);
    end
    check("busy_mid_frame", int'(busy), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midframe_reset_outputs", int'({rx_data, rx_valid, frame_err, overrun, busy}), 0);
    UART_RX = 1'b1;
    tick(6*C);
    check("after_abort_idle", int'({rx_data, rx_valid, frame_err, overrun, busy}), 0);
    send(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("after_reset_flags_clear", int'({frame_err, overrun}), 0);

    tick(20);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
